// File: rtl/vector_checker.sv
// vector_checker: exhaustive truth-table checker for a small combinational DUT.
// Walks every input vector, holds each one for SETTLE cycles, samples dut_out
// on the last settle cycle and compares it with EXPECTED[vector].
// Optional build macro FAIL_MAP_EN adds a per-vector mismatch bitmap (fail_map).
module vector_checker #(
    parameter int unsigned        N_IN     = 3,
    parameter int unsigned        SETTLE   = 5,
    parameter logic [2**N_IN-1:0] EXPECTED = 8'b0000_0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     fail_count,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid,
    output logic [1:0]        fsm_state
`ifdef FAIL_MAP_EN
    ,
    output logic [2**N_IN-1:0] fail_map
`endif
);

    // Handshake: start is a level, not a valid/ready pair. It is honoured on any
    // edge where the FSM is in IDLE or DONE and ignored while RUN is active; the
    // run's completion is signalled by done, which stays high until the next
    // accepted start or reset.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST    = '1;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] settle_cnt;
    logic       run_start;
    logic       sample;
    logic       last_sample;
    logic       mismatch;

    assign fsm_state = state;
    assign mismatch  = sample && (dut_out != EXPECTED[dut_in]);
    assign pass      = done && (fail_count == '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: start launches a run from IDLE or DONE; the final sample ends it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = RUN;
            RUN:        if (last_sample) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Control decode: run launch, per-vector sample point and the final sample
    always_comb begin
        run_start   = 1'b0;
        sample      = 1'b0;
        last_sample = 1'b0;
        case (state)
            IDLE, DONE: run_start = start;
            RUN: begin
                sample      = (settle_cnt == SETTLE_LAST);
                last_sample = sample && (dut_in == VEC_LAST);
            end
            default: ;
        endcase
    end

    // Vector sequencer: dut_in doubles as the vector index and is 0 outside RUN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dut_in     <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (run_start) begin
            dut_in     <= '0;
            settle_cnt <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else if (state == RUN) begin
            if (sample) begin
                settle_cnt <= '0;
                dut_in     <= last_sample ? '0 : dut_in + 1'b1;
            end else begin
                settle_cnt <= settle_cnt + 8'd1;
            end
            if (last_sample) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    // Result capture: failure count and the first failing vector of the run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_count       <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (run_start) begin
            fail_count       <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (mismatch) begin
            fail_count <= fail_count + 1'b1;
            if (!first_fail_valid) begin
                first_fail_vec   <= dut_in;
                first_fail_valid <= 1'b1;
            end
        end
    end

`ifdef FAIL_MAP_EN
    // Mismatch bitmap: one sticky bit per vector, cleared when a run starts
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          fail_map <= '0;
        else if (run_start) fail_map <= '0;
        else if (mismatch)  fail_map[dut_in] <= 1'b1;
    end
`else
    // Without the bitmap only the count and first failing vector are kept.
`endif

endmodule

// File: tb/tb_vector_checker.sv
// tb_vector_checker: directed runs of vector_checker against behavioural DUTs,
// with expected results queued at start and checked when done rises.
module tb_vector_checker;

    localparam int NV   = 8;
    localparam int SET0 = 5;
    localparam int SET1 = 1;

    logic clk = 1'b0;
    logic reset;

    logic       start_a [2];
    logic [2:0] din_a   [2];
    logic       dout_a  [2];
    logic       busy_a  [2];
    logic       done_a  [2];
    logic       pass_a  [2];
    logic [3:0] fc_a    [2];
    logic [2:0] ffvec_a [2];
    logic       ffv_a   [2];
    logic [1:0] st_a    [2];
`ifdef FAIL_MAP_EN
    logic [7:0] map_a   [2];
`endif

    int         mode_a [2];
    logic [7:0] rand_tbl;
    logic [7:0] exp_tt = 8'b0000_0001;

    int checks = 0;
    int errors = 0;
    int wait_k;

    // Scoreboard queues: {fail_count, first_fail_valid, first_fail_vec, pass}
    logic [8:0] exp_q [$];
    logic [7:0] map_q [$];
    logic [2:0] din_q [$];

    // Clock
    always #5 clk = ~clk;

    // Behavioural DUTs: 0 = NOT(A|B|C), 1 = tied 1, 2 = tied 0, else table lookup
    function automatic logic dut_fn(input int md, input logic [7:0] tbl, input logic [2:0] v);
        case (md)
            0:       return ~(v[2] | v[1] | v[0]);
            1:       return 1'b1;
            2:       return 1'b0;
            default: return tbl[v];
        endcase
    endfunction

    assign dout_a[0] = dut_fn(mode_a[0], rand_tbl, din_a[0]);
    assign dout_a[1] = dut_fn(mode_a[1], rand_tbl, din_a[1]);

    vector_checker #(.N_IN(3), .SETTLE(SET0), .EXPECTED(8'b0000_0001)) u_dut0 (
        .clk              (clk),
        .reset            (reset),
        .start            (start_a[0]),
        .dut_in           (din_a[0]),
        .dut_out          (dout_a[0]),
        .busy             (busy_a[0]),
        .done             (done_a[0]),
        .pass             (pass_a[0]),
        .fail_count       (fc_a[0]),
        .first_fail_vec   (ffvec_a[0]),
        .first_fail_valid (ffv_a[0]),
        .fsm_state        (st_a[0])
`ifdef FAIL_MAP_EN
        ,
        .fail_map         (map_a[0])
`endif
    );

    vector_checker #(.N_IN(3), .SETTLE(SET1), .EXPECTED(8'b0000_0001)) u_dut1 (
        .clk              (clk),
        .reset            (reset),
        .start            (start_a[1]),
        .dut_in           (din_a[1]),
        .dut_out          (dout_a[1]),
        .busy             (busy_a[1]),
        .done             (done_a[1]),
        .pass             (pass_a[1]),
        .fail_count       (fc_a[1]),
        .first_fail_vec   (ffvec_a[1]),
        .first_fail_valid (ffv_a[1]),
        .fsm_state        (st_a[1])
`ifdef FAIL_MAP_EN
        ,
        .fail_map         (map_a[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input int sel, input string tag);
        chk({tag, "_busy"},  busy_a[sel],  0);
        chk({tag, "_done"},  done_a[sel],  0);
        chk({tag, "_pass"},  pass_a[sel],  0);
        chk({tag, "_fc"},    fc_a[sel],    0);
        chk({tag, "_ffvec"}, ffvec_a[sel], 0);
        chk({tag, "_ffv"},   ffv_a[sel],   0);
        chk({tag, "_dut_in"}, din_a[sel],  0);
        chk({tag, "_state"}, st_a[sel],    0);
`ifdef FAIL_MAP_EN
        chk({tag, "_map"},   map_a[sel],   0);
`endif
    endtask

    // Driver + scoreboard for one complete run. Called at a negedge; returns at
    // the negedge where done was observed (plus hold_n cycles of hold checks).
    task automatic do_run(input int sel, input int md, input int pulse_k, input int hold_n);
        int         settle;
        int         lat;
        int         k;
        logic [3:0] fc;
        logic       ffv;
        logic [2:0] ffvec;
        logic [7:0] map;
        logic [8:0] res;
        logic [7:0] res_map;
        logic [2:0] din_exp;
        settle = (sel == 0) ? SET0 : SET1;
        lat    = NV * settle;
        mode_a[sel] = md;
        fc = 0; ffv = 0; ffvec = 0; map = 0;
        for (int v = 0; v < NV; v++) begin
            if (dut_fn(md, rand_tbl, 3'(v)) != exp_tt[v]) begin
                fc++;
                if (!ffv) begin
                    ffv   = 1'b1;
                    ffvec = 3'(v);
                end
                map[v] = 1'b1;
            end
        end
        exp_q.push_back({fc, ffv, ffvec, (fc == 4'd0)});
        map_q.push_back(map);
        for (int i = 0; i < lat; i++) din_q.push_back(3'(i / settle));
        din_q.push_back(3'd0);

        start_a[sel] = 1'b1;
        @(negedge clk);
        start_a[sel] = 1'b0;
        chk("start_busy",    busy_a[sel], 1);
        chk("start_done_clr", done_a[sel], 0);
        chk("start_fc_clr",  fc_a[sel],   0);
        chk("start_ffv_clr", ffv_a[sel],  0);
        chk("start_state",   st_a[sel],   1);

        k = 0;
        while (k <= lat + 4) begin
            start_a[sel] = (k == pulse_k);
            if (din_q.size() > 0) begin
                din_exp = din_q.pop_front();
                chk("dut_in_seq", din_a[sel], din_exp);
            end
            if (done_a[sel]) break;
            chk("busy_run", busy_a[sel], 1);
            @(negedge clk);
            k++;
        end
        start_a[sel] = 1'b0;
        din_q.delete();

        chk("done_latency", k, lat);
        chk("done_busy",    busy_a[sel], 0);
        chk("done_state",   st_a[sel],   2);
        res     = exp_q.pop_front();
        res_map = map_q.pop_front();
        chk("fail_count", fc_a[sel],  res[8:5]);
        chk("ffv",        ffv_a[sel], res[4]);
        if (res[4]) chk("first_fail_vec", ffvec_a[sel], res[3:1]);
        chk("pass",       pass_a[sel], res[0]);
`ifdef FAIL_MAP_EN
        chk("fail_map",   map_a[sel], res_map);
`endif
        for (int h = 0; h < hold_n; h++) begin
            @(negedge clk);
            chk("hold_done", done_a[sel], 1);
            chk("hold_fc",   fc_a[sel],   res[8:5]);
            chk("hold_din",  din_a[sel],  0);
            chk("hold_pass", pass_a[sel], res[0]);
        end
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // Directed sequence
    initial begin
        reset      = 1'b1;
        start_a[0] = 1'b0;
        start_a[1] = 1'b0;
        mode_a[0]  = 0;
        mode_a[1]  = 0;
        rand_tbl   = 8'h00;
        repeat (3) @(negedge clk);
        check_zero(0, "rst0");
        check_zero(1, "rst1");
        reset = 1'b0;
        @(negedge clk);
        check_zero(0, "idle0");

        // NOT(A|B|C) matches the table: pass, then results hold in DONE
        do_run(0, 0, -1, 3);
        // Tied-1 DUT, started from DONE, with a stray start pulse mid-run
        do_run(0, 1, 7, 2);
        // SETTLE=1 instance: tied-0 fails only vector 0
        do_run(1, 2, -1, 1);
        do_run(1, 0, 3, 0);
        // Random truth tables, back-to-back with start taken on the done cycle
        for (int r = 0; r < 3; r++) begin
            rand_tbl = 8'($urandom_range(0, 255));
            do_run(0, 3, -1, 0);
        end

        // Asynchronous reset at vector 4
        mode_a[0]  = 1;
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        wait_k = 0;
        while (din_a[0] != 3'd4 && wait_k < 40) begin
            @(negedge clk);
            wait_k++;
        end
        chk("mid_reach_vec4", din_a[0], 4);
        chk("mid_fc_before",  fc_a[0],  3);
        #2 reset = 1'b1;
        #1;
        check_zero(0, "mid_rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_run(0, 1, -1, 1);

        rand_tbl = 8'($urandom_range(0, 255));
        do_run(1, 3, -1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
